// File: rtl/rotate_pkg.sv
// Shared definitions for the shared-rotator arbiter: widths, direction codes
// and the response-slot state encoding.
package rotate_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SHW_DEF    = 5;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : rotate_pkg

// File: rtl/barrel_rotator.sv
// Purely combinational barrel rotator; the amount is implicitly modulo DATA_W
// because shift_amount is exactly log2(DATA_W) bits wide.
module barrel_rotator
  import rotate_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHW    = SHW_DEF
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [SHW-1:0]    shift_amount,
  input  logic              direction,
  output logic [DATA_W-1:0] data_out
);

  // Rotating a doubled copy avoids the DATA_W-0 full-width shift when amount is 0.
  logic [2*DATA_W-1:0] dbl_s;
  logic [2*DATA_W-1:0] dbl_r_s;
  logic [2*DATA_W-1:0] dbl_l_s;

  assign dbl_s   = {data_in, data_in};
  assign dbl_r_s = dbl_s >> shift_amount;
  assign dbl_l_s = dbl_s << shift_amount;

  // Direction select.
  always_comb begin
    data_out = {DATA_W{1'b0}};
    case (direction)
      DIR_RIGHT: data_out = dbl_r_s[DATA_W-1:0];
      DIR_LEFT:  data_out = dbl_l_s[2*DATA_W-1:DATA_W];
      default:   data_out = {DATA_W{1'b0}};
    endcase
  end

endmodule : barrel_rotator

// File: rtl/rotate_share_arb.sv
// Two-requester round-robin front end for one shared barrel rotator, with a
// single registered response slot and an accepted-transaction counter.
module rotate_share_arb
  import rotate_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHW    = SHW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [SHW-1:0]    req0_amt,
  input  logic              req0_dir,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [SHW-1:0]    req1_amt,
  input  logic              req1_dir,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic [15:0]       busy_cnt
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              last_grant_r;
  logic              slot_free_s;
  logic              grant0_s;
  logic              grant1_s;
  logic              accept_s;
  logic              sel_s;
  logic [DATA_W-1:0] mux_data_s;
  logic [SHW-1:0]    mux_amt_s;
  logic              mux_dir_s;
  logic [DATA_W-1:0] rot_out_s;

  assign slot_free_s = (state_r == IDLE) | (rsp_valid & rsp_ready);

  // Round-robin grant: on contention the requester that did not win last time goes.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (slot_free_s) begin
      grant0_s = req0_valid & (~req1_valid | (last_grant_r == 1'b1));
      grant1_s = req1_valid & (~req0_valid | (last_grant_r == 1'b0));
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign accept_s   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign sel_s      = grant1_s;

  // Steer the granted command onto the single shared rotator.
  always_comb begin
    mux_data_s = req0_data;
    mux_amt_s  = req0_amt;
    mux_dir_s  = req0_dir;
    if (sel_s) begin
      mux_data_s = req1_data;
      mux_amt_s  = req1_amt;
      mux_dir_s  = req1_dir;
    end else begin
      mux_data_s = req0_data;
      mux_amt_s  = req0_amt;
      mux_dir_s  = req0_dir;
    end
  end

  barrel_rotator #(
    .DATA_W (DATA_W),
    .SHW    (SHW)
  ) u_rot (
    .data_in      (mux_data_s),
    .shift_amount (mux_amt_s),
    .direction    (mux_dir_s),
    .data_out     (rot_out_s)
  );

  // Response-slot next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = HOLD;
        else          state_nxt_s = IDLE;
      end
      HOLD: begin
        if (accept_s)       state_nxt_s = HOLD;
        else if (rsp_ready) state_nxt_s = IDLE;
        else                state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Result capture, round-robin pointer and acceptance counter; data held when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data     <= {DATA_W{1'b0}};
      rsp_id       <= 1'b0;
      last_grant_r <= 1'b1;
      busy_cnt     <= 16'd0;
    end else if (accept_s) begin
      rsp_data     <= rot_out_s;
      rsp_id       <= sel_s;
      last_grant_r <= sel_s;
      busy_cnt     <= busy_cnt + 16'd1;
    end else begin
      rsp_data     <= rsp_data;
      rsp_id       <= rsp_id;
      last_grant_r <= last_grant_r;
      busy_cnt     <= busy_cnt;
    end
  end

  assign rsp_valid = (state_r == HOLD);

endmodule : rotate_share_arb
